// File: rtl/hdc_pkg.sv
// Shared types for the hypervector prototype trainer: class labels,
// controller states and the default counter width.
// Optional build macro PROTO_AUTOCLEAR_EN adds the CLEAR state.
`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

package hdc_pkg;

  localparam int DEFAULT_CNT_WIDTH = 8;
  localparam int NUM_CLASSES       = 4;

  typedef enum logic [1:0] {
    CLS_V_PLUS = 2'd0,
    CLS_V_MIN  = 2'd1,
    CLS_A_HIGH = 2'd2,
    CLS_A_LOW  = 2'd3
  } class_e;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_EMIT  = 2'd1
`ifdef PROTO_AUTOCLEAR_EN
    ,
    ST_CLEAR = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/prototype_trainer_if.sv
// Handshake bundle between the trainer and its producer/consumer.
// master drives samples, finalize requests and dout_ready; slave is the trainer.
interface prototype_trainer_if #(
  parameter int HV_DIM = `HV_DIMENSION
);
  logic              hvin_valid;
  logic              hvin_ready;
  logic [HV_DIM-1:0] hvin;
  logic              hvin_valence;
  logic              hvin_arousal;
  logic              finalize_valid;
  logic              finalize_ready;
  logic              dout_valid;
  logic              dout_ready;
  logic [1:0]        dout_class;
  logic [HV_DIM-1:0] dout_hv;
  logic              full;

  modport master (
    output hvin_valid, hvin, hvin_valence, hvin_arousal, finalize_valid, dout_ready,
    input  hvin_ready, finalize_ready, dout_valid, dout_class, dout_hv, full
  );

  modport slave (
    input  hvin_valid, hvin, hvin_valence, hvin_arousal, finalize_valid, dout_ready,
    output hvin_ready, finalize_ready, dout_valid, dout_class, dout_hv, full
  );
endinterface

// File: rtl/proto_accumulator.sv
// One class's accumulator: a sample counter plus one ones-counter per bit,
// with a combinational majority vote producing the class prototype.
// Ones counters never overflow because each is bounded by the sample count,
// and the parent stops accepting samples once the count saturates.
module proto_accumulator
  import hdc_pkg::*;
#(
  parameter int HV_DIM    = `HV_DIMENSION,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [HV_DIM-1:0] hv,
  output logic              sat,
  output logic [HV_DIM-1:0] proto
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] ones [HV_DIM];

  // Count samples and per-bit ones; reset and clear both zero everything.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
      for (int i = 0; i < HV_DIM; i++) ones[i] <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
      for (int i = 0; i < HV_DIM; i++) begin
        if (hv[i]) ones[i] <= ones[i] + 1'b1;
      end
    end
  end

  assign sat = (count == CNT_MAX);

  // Strict majority at CNT_WIDTH+1 bits; ties and empty classes give 0.
  always_comb begin
    proto = '0;
    for (int i = 0; i < HV_DIM; i++) begin
      proto[i] = ({ones[i], 1'b0} > {1'b0, count});
    end
  end

endmodule

// File: rtl/prototype_trainer.sv
// Hypervector prototype trainer: accumulates labelled samples into four
// class accumulators and, on a finalize request, emits the four majority
// prototypes in class order over a valid/ready port.
// Build macro PROTO_AUTOCLEAR_EN: when defined, one CLEAR cycle after the
// last prototype zeroes all counters; otherwise counters are retained.
//
// state    | meaning
// ST_TRAIN | accepting samples and finalize requests
// ST_EMIT  | presenting prototypes 0..3, accumulators frozen
// ST_CLEAR | one cycle zeroing accumulators (PROTO_AUTOCLEAR_EN only)
module prototype_trainer
  import hdc_pkg::*;
#(
  parameter int HV_DIM    = `HV_DIMENSION,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  prototype_trainer_if.slave bus
);

  state_e                  state;
  logic                    dout_valid_q;
  class_e                  dout_class_q;
  logic [HV_DIM-1:0]       dout_hv_q;

  logic                    full;
  logic                    clr;
  logic                    hvin_ready;
  logic                    finalize_ready;
  logic                    hvin_fire;
  logic                    fin_fire;
  logic                    dout_fire;
  logic [NUM_CLASSES-1:0]  inc;
  logic [NUM_CLASSES-1:0]  sat;
  logic [HV_DIM-1:0]       proto [NUM_CLASSES];
  logic [1:0]              next_cls;

  // A pending finalize wins over a sample in the same cycle.
  assign hvin_ready     = (state == ST_TRAIN) && !bus.finalize_valid && !full;
  assign finalize_ready = (state == ST_TRAIN);
  assign hvin_fire      = bus.hvin_valid && hvin_ready;
  assign fin_fire       = bus.finalize_valid && finalize_ready;
  assign dout_fire      = dout_valid_q && bus.dout_ready;
  assign full           = |sat;
  assign next_cls       = dout_class_q + 2'd1;

  // Each sample lands in one valence class and one arousal class.
  assign inc[CLS_V_PLUS] = hvin_fire && !bus.hvin_valence;
  assign inc[CLS_V_MIN]  = hvin_fire &&  bus.hvin_valence;
  assign inc[CLS_A_HIGH] = hvin_fire && !bus.hvin_arousal;
  assign inc[CLS_A_LOW]  = hvin_fire &&  bus.hvin_arousal;

`ifdef PROTO_AUTOCLEAR_EN
  assign clr = (state == ST_CLEAR);
`else
  assign clr = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_acc
    proto_accumulator #(
      .HV_DIM    (HV_DIM),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc[g]),
      .hv    (bus.hvin),
      .sat   (sat[g]),
      .proto (proto[g])
    );
  end

  // Controller: registered output stage walks classes 0..3 on each dout fire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_TRAIN;
      dout_valid_q <= 1'b0;
      dout_class_q <= CLS_V_PLUS;
      dout_hv_q    <= '0;
    end else begin
      case (state)
        ST_TRAIN: begin
          if (fin_fire) begin
            state        <= ST_EMIT;
            dout_valid_q <= 1'b1;
            dout_class_q <= CLS_V_PLUS;
            dout_hv_q    <= proto[CLS_V_PLUS];
          end
        end
        ST_EMIT: begin
          if (dout_fire) begin
            if (dout_class_q == CLS_A_LOW) begin
              dout_valid_q <= 1'b0;
`ifdef PROTO_AUTOCLEAR_EN
              state        <= ST_CLEAR;
`else
              state        <= ST_TRAIN;
`endif
            end else begin
              dout_class_q <= class_e'(next_cls);
              dout_hv_q    <= proto[next_cls];
            end
          end
        end
`ifdef PROTO_AUTOCLEAR_EN
        ST_CLEAR: begin
          state <= ST_TRAIN;
        end
`endif
        default: begin
          state <= ST_TRAIN;
        end
      endcase
    end
  end

  assign bus.hvin_ready     = hvin_ready;
  assign bus.finalize_ready = finalize_ready;
  assign bus.dout_valid     = dout_valid_q;
  assign bus.dout_class     = dout_class_q;
  assign bus.dout_hv        = dout_hv_q;
  assign bus.full           = full;

endmodule

// File: tb/tb_prototype_trainer.sv
// Directed bench for prototype_trainer (HV_DIM=8, CNT_WIDTH=3) with a
// per-class counter model feeding a scoreboard of expected prototypes.
module tb_prototype_trainer;

  typedef struct {
    logic [1:0] cls;
    logic [7:0] hv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prototype_trainer_if #(.HV_DIM(8)) bus ();

  prototype_trainer #(
    .HV_DIM    (8),
    .CNT_WIDTH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_cnt  [4];
  int   m_ones [4][8];
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      for (int i = 0; i < 8; i++) m_ones[c][i] = 0;
    end
  endtask

  task automatic m_add_cls(input int c, input logic [7:0] hv);
    m_cnt[c]++;
    for (int i = 0; i < 8; i++) if (hv[i]) m_ones[c][i]++;
  endtask

  function automatic logic m_full();
    logic f;
    f = 1'b0;
    for (int c = 0; c < 4; c++) if (m_cnt[c] == 7) f = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] m_proto(input int c);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = (2 * m_ones[c][i] > m_cnt[c]);
    return r;
  endfunction

  task automatic send(input logic [7:0] hv, input logic val, input logic aro);
    logic exp_rdy;
    exp_rdy          = !m_full();
    bus.hvin         = hv;
    bus.hvin_valence = val;
    bus.hvin_arousal = aro;
    bus.hvin_valid   = 1'b1;
    #1;
    check("hvin_ready", bus.hvin_ready, exp_rdy);
    if (exp_rdy) begin
      m_add_cls(val ? 1 : 0, hv);
      m_add_cls(aro ? 3 : 2, hv);
    end
    tick();
    bus.hvin_valid = 1'b0;
  endtask

  // Finalize with a competing sample offered; the sample must be refused.
  task automatic finalize();
    exp_t e;
    bus.finalize_valid = 1'b1;
    bus.hvin           = 8'hFF;
    bus.hvin_valid     = 1'b1;
    #1;
    check("hvin_ready_blocked_by_finalize", bus.hvin_ready, 1'b0);
    check("finalize_ready", bus.finalize_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      e.cls = 2'(c);
      e.hv  = m_proto(c);
      sb.push_back(e);
    end
    tick();
    bus.finalize_valid = 1'b0;
    bus.hvin_valid     = 1'b0;
  endtask

  task automatic collect(input int stall_k, input int stall_n);
    exp_t e;
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = sb.pop_front();
      check("dout_valid", bus.dout_valid, 1'b1);
      check("dout_class", bus.dout_class, e.cls);
      check("dout_hv", bus.dout_hv, e.hv);
      if (k == stall_k) begin
        bus.dout_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("stall_dout_valid", bus.dout_valid, 1'b1);
          check("stall_dout_class", bus.dout_class, e.cls);
          check("stall_dout_hv", bus.dout_hv, e.hv);
        end
        bus.dout_ready = 1'b1;
      end
      tick();
    end
    check("dout_valid_after_last", bus.dout_valid, 1'b0);
`ifdef PROTO_AUTOCLEAR_EN
    check("clear_finalize_ready", bus.finalize_ready, 1'b0);
    check("clear_hvin_ready", bus.hvin_ready, 1'b0);
    m_clear();
    tick();
`endif
    check("back_to_train", bus.finalize_ready, 1'b1);
  endtask

  initial begin
    exp_t e;
    bus.hvin_valid     = 1'b0;
    bus.hvin           = 8'h00;
    bus.hvin_valence   = 1'b0;
    bus.hvin_arousal   = 1'b0;
    bus.finalize_valid = 1'b0;
    bus.dout_ready     = 1'b1;
    m_clear();

    // Reset for two cycles, then release.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_hvin_ready", bus.hvin_ready, 1'b1);
    check("rst_finalize_ready", bus.finalize_ready, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_dout_class", bus.dout_class, 2'd0);
    check("rst_dout_hv", bus.dout_hv, 8'h00);

    // First training round and emission.
    send(8'hF0, 1'b0, 1'b1);
    send(8'hF0, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b1);
    finalize();
    collect(-1, 0);

    // Re-finalize with no new samples.
    finalize();
    collect(-1, 0);

    // Tie rule on V_MIN, with a 5-cycle stall on class 1.
    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    finalize();
    collect(1, 5);

    // Fresh reset, then saturate V_PLUS / A_HIGH.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_clear();
    check("rst2_full", bus.full, 1'b0);
    for (int s = 0; s < 7; s++) begin
      send(8'((16'h1 << (s + 1)) - 16'h1), 1'b0, 1'b0);
      check("full_progress", bus.full, m_full());
    end
    bus.hvin       = 8'hAA;
    bus.hvin_valid = 1'b1;
    #1;
    check("full_blocks_hvin", bus.hvin_ready, 1'b0);
    tick();
    check("full_blocks_hvin_held", bus.hvin_ready, 1'b0);
    finalize();
    e = sb.pop_front();
    check("full_emit_valid", bus.dout_valid, 1'b1);
    check("full_emit_class", bus.dout_class, e.cls);
    check("full_emit_hv", bus.dout_hv, e.hv);

    // Reset mid-emission.
    bus.dout_ready = 1'b0;
    rst = 1'b0;
    tick();
    check("midemit_rst_dout_valid", bus.dout_valid, 1'b0);
    check("midemit_rst_dout_class", bus.dout_class, 2'd0);
    check("midemit_rst_dout_hv", bus.dout_hv, 8'h00);
    check("midemit_rst_full", bus.full, 1'b0);
    sb.delete();
    m_clear();
    rst = 1'b1;
    bus.hvin_valid = 1'b0;
    bus.dout_ready = 1'b1;
    #1;
    check("post_rst_hvin_ready", bus.hvin_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
